uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BIT_RATE, default 9600, serial bit rate in bits/s.
REQ-002 Parameter CLK_HZ, default 50000000, frequency of clk in Hz.
REQ-003 Parameter PAYLOAD_BITS, default 8, data bits per frame.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame (1 or 2).
REQ-005 clk  input  1  single system clock; all logic on the rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 uart_rxd  input  1  serial receive pin, asynchronous to clk, idle high.
REQ-008 uart_rx_en  input  1  receiver enable; while low, no new frame is started.
REQ-009 uart_rx_break  output  1  one-cycle pulse: a full frame sampled all-zero (line break).
REQ-010 uart_rx_valid  output  1  one-cycle pulse: uart_rx_data holds a new good frame.
REQ-011 uart_rx_data  output  PAYLOAD_BITS  last received payload, LSB first on the line.
REQ-012 uart_rx_frame_err  output  1  one-cycle pulse: a stop bit sampled low.

Function
REQ-013 CYCLES_PER_BIT SHALL be CLK_HZ/BIT_RATE (integer division); the half-bit count SHALL be CYCLES_PER_BIT/2; counters SHALL be sized with $clog2(CYCLES_PER_BIT+1).
REQ-014 uart_rxd SHALL pass through a 2-flop synchronizer before any use; all sample points below refer to the synchronized signal (2-cycle input latency).
REQ-015 FSM states: IDLE, START, DATA, PARITY (only when the macro is defined), STOP, DONE.
REQ-016 IDLE -> START on synchronized high-to-low transition while uart_rx_en=1; the bit counter SHALL be cleared.
REQ-017 START: after half-bit count, line low -> DATA; line high -> IDLE (glitch rejected, no output pulse).
REQ-018 DATA: sample each bit after CYCLES_PER_BIT cycles, shift in LSB first; after PAYLOAD_BITS samples -> PARITY or STOP.
REQ-019 STOP: sample STOP_BITS bits at CYCLES_PER_BIT spacing; any low stop sample SHALL mark a frame error.
REQ-020 DONE lasts exactly one cycle and then -> IDLE. In that cycle exactly one of these SHALL pulse: uart_rx_break (all data and stop samples low, frame error implied), uart_rx_frame_err, parity error, or uart_rx_valid.
REQ-021 uart_rx_data SHALL update only in the cycle uart_rx_valid pulses and hold otherwise; on an error it SHALL keep the previous value.
REQ-022 After a break, IDLE SHALL NOT start a new frame until the synchronized line has been high for at least one cycle.
REQ-023 Deasserting uart_rx_en mid-frame SHALL NOT abort the frame; it gates only the IDLE -> START transition.
REQ-024 A start edge arriving during DONE SHALL be detected in IDLE on the next cycle if the line is still low; the frame SHALL be accepted provided the START half-bit check passes.

Reset
REQ-025 resetn low SHALL asynchronously force: FSM=IDLE, counters=0, synchronizer flops=1, uart_rx_data=0, and all pulse outputs=0.
REQ-026 Reset mid-frame SHALL discard the partial frame with no output pulse; reception resumes at the next start edge after release.

Configuration
REQ-027 Macro UART_RX_PARITY_EN: when defined, one even-parity bit follows the data (state PARITY), and output uart_rx_parity_err (1 bit) pulses in DONE on mismatch instead of uart_rx_valid.
REQ-028 When UART_RX_PARITY_EN is undefined, the PARITY state and uart_rx_parity_err port SHALL not exist, and the frame is start + data + stop.

Structure
REQ-029 Shared package uart_pkg SHALL hold the FSM state encoding and the CYCLES_PER_BIT/half-bit constant functions, and SHALL be shared with UART_TX.
REQ-030 Sub-module uart_sync2 (2-flop synchronizer, reset value 1) SHALL be instantiated for uart_rxd.

Verification (BIT_RATE=9600, CLK_HZ=50000000, CYCLES_PER_BIT=5208)
REQ-031 Serial frame 0xA5, good stop -> one uart_rx_valid pulse, uart_rx_data=0xA5, no error pulses.
REQ-032 20 back-to-back random bytes, minimum idle between frames -> 20 valid pulses whose data matches in order.
REQ-033 Stop bit driven low on byte 0x3C -> uart_rx_frame_err pulse, no valid pulse, uart_rx_data unchanged.
REQ-034 100 ns low glitch on idle line -> FSM returns to IDLE, no output pulse; line held low for 12 bit times -> exactly one uart_rx_break pulse.
REQ-035 resetn pulsed low during bit 4 of 0xFF -> no pulse; the next frame 0x5A is received correctly.
REQ-036 With UART_RX_PARITY_EN: byte 0x07 sent with wrong parity -> uart_rx_parity_err pulse and no valid pulse; sent with correct parity -> valid pulse and uart_rx_data=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding and bit-timing helpers shared by UART_RX and UART_TX.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
package uart_pkg;

    // Frame-sequencing states; PARITY exists only in parity-enabled builds.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } uart_state_e;

    // Whole clock cycles per serial bit (truncating division).
    function automatic int unsigned f_cycles_per_bit(input int unsigned clk_hz,
                                                     input int unsigned bit_rate);
        return clk_hz / bit_rate;
    endfunction

    // Cycles from the start edge to the centre of the start bit.
    function automatic int unsigned f_half_bit(input int unsigned clk_hz,
                                               input int unsigned bit_rate);
        return f_cycles_per_bit(clk_hz, bit_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous level, resets to 1 (idle line).
module uart_sync2 (
    input  logic clk,
    input  logic resetn,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, start + PAYLOAD_BITS data (LSB first) + STOP_BITS stop bits.
// Optional feature macro: UART_RX_PARITY_EN adds one even-parity bit and uart_rx_parity_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_break,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic                    uart_rx_parity_err
`endif
);

    localparam int unsigned CYCLES_PER_BIT = f_cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int unsigned HALF_BIT       = f_half_bit(CLK_HZ, BIT_RATE);
    localparam int unsigned CNT_W          = $clog2(CYCLES_PER_BIT + 1);
    localparam int unsigned BIT_W          = $clog2(PAYLOAD_BITS + STOP_BITS + 1);

    logic                    w_rxd;

    uart_state_e             r_state;
    uart_state_e             w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [BIT_W-1:0]        r_bit;
    logic [BIT_W-1:0]        w_bit_nxt;
    logic [PAYLOAD_BITS-1:0] r_shift;
    logic [PAYLOAD_BITS-1:0] w_shift_nxt;
    logic                    r_ferr;
    logic                    w_ferr_nxt;
    logic                    r_prev_hi;
    logic                    w_prev_hi_nxt;
    logic [PAYLOAD_BITS-1:0] r_data;
    logic [PAYLOAD_BITS-1:0] w_data_nxt;
    logic                    r_valid;
    logic                    w_valid_nxt;
    logic                    r_break;
    logic                    w_break_nxt;
    logic                    r_ferr_p;
    logic                    w_ferr_p_nxt;
`ifdef UART_RX_PARITY_EN
    logic                    r_perr;
    logic                    w_perr_nxt;
    logic                    r_perr_p;
    logic                    w_perr_p_nxt;
`endif

    logic                    w_bit_end;
    logic                    w_half_end;

    uart_sync2 u_sync (
        .clk    (clk),
        .resetn (resetn),
        .i_d    (uart_rxd),
        .o_q    (w_rxd)
    );

    assign w_bit_end  = (r_cnt == CNT_W'(CYCLES_PER_BIT - 1));
    assign w_half_end = (r_cnt == CNT_W'(HALF_BIT - 1));

    // State, timing counters and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_ferr    <= 1'b0;
            r_prev_hi <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_break   <= 1'b0;
            r_ferr_p  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr    <= 1'b0;
            r_perr_p  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_ferr    <= w_ferr_nxt;
            r_prev_hi <= w_prev_hi_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_break   <= w_break_nxt;
            r_ferr_p  <= w_ferr_p_nxt;
`ifdef UART_RX_PARITY_EN
            r_perr    <= w_perr_nxt;
            r_perr_p  <= w_perr_p_nxt;
`endif
        end
    end

    // Next-state, sampling and result decode; result pulses are set on entry to DONE.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bit_nxt    = r_bit;
        w_shift_nxt  = r_shift;
        w_ferr_nxt   = r_ferr;
        w_data_nxt   = r_data;
        w_valid_nxt  = 1'b0;
        w_break_nxt  = 1'b0;
        w_ferr_p_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr_nxt   = r_perr;
        w_perr_p_nxt = 1'b0;
`endif
        // Line-was-high memory; frozen through DONE so an edge there still starts a frame.
        // A line held low (e.g. after a break) never re-arms until it has been seen high.
        w_prev_hi_nxt = w_rxd | ((r_state == ST_DONE) & r_prev_hi);

        unique case (r_state)
            ST_IDLE: begin
                if (uart_rx_en && r_prev_hi && !w_rxd) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
                    w_perr_nxt  = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (w_half_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_rxd ? ST_IDLE : ST_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rxd, r_shift[PAYLOAD_BITS-1:1]};
                    if (r_bit == BIT_W'(PAYLOAD_BITS - 1)) begin
                        w_bit_nxt   = '0;
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit + BIT_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_perr_nxt  = (^r_shift) ^ w_rxd;
                    w_state_nxt = ST_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (!w_rxd) begin
                        w_ferr_nxt = 1'b1;
                    end
                    if (r_bit == BIT_W'(STOP_BITS - 1)) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = ST_DONE;
                        if (w_ferr_nxt && (r_shift == '0)) begin
                            w_break_nxt = 1'b1;
                        end else if (w_ferr_nxt) begin
                            w_ferr_p_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (r_perr) begin
                            w_perr_p_nxt = 1'b1;
`endif
                        end else begin
                            w_valid_nxt = 1'b1;
                            w_data_nxt  = r_shift;
                        end
                    end else begin
                        w_bit_nxt = r_bit + BIT_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign uart_rx_break     = r_break;
    assign uart_rx_valid     = r_valid;
    assign uart_rx_data      = r_data;
    assign uart_rx_frame_err = r_ferr_p;
`ifdef UART_RX_PARITY_EN
    assign uart_rx_parity_err = r_perr_p;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames checked against a frame-level model.
// Optional feature macro: UART_RX_PARITY_EN (parity frames and parity checks).
module tb_uart_rx;

    localparam int unsigned CLK_HZ   = 50_000_000;
    localparam int unsigned BIT_RATE = 3_000_000;
    localparam int unsigned PB       = 8;
    localparam int unsigned SB       = 1;
    localparam int unsigned CPB      = CLK_HZ / BIT_RATE;

`ifdef UART_RX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    // Pulse vector layout: {break, frame_err, parity_err, valid}
    localparam logic [3:0] P_NONE  = 4'b0000;
    localparam logic [3:0] P_VALID = 4'b0001;
    localparam logic [3:0] P_PERR  = 4'b0010;
    localparam logic [3:0] P_FERR  = 4'b0100;
    localparam logic [3:0] P_BRK   = 4'b1000;

    typedef struct packed {
        logic [3:0]    pulses;
        logic [PB-1:0] data;
    } ev_t;

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic          rxd    = 1'b1;
    logic          en     = 1'b1;
    logic          brk_o;
    logic          valid_o;
    logic [PB-1:0] data_o;
    logic          ferr_o;
    logic          perr_o;

    ev_t           exp_q[$];
    logic [PB-1:0] mdl_data  = '0;
    int            n_checks  = 0;
    int            n_fail    = 0;
    int            cnt_valid = 0;
    int            cnt_ferr  = 0;
    int            cnt_perr  = 0;
    int            cnt_brk   = 0;

    uart_rx #(
        .BIT_RATE     (BIT_RATE),
        .CLK_HZ       (CLK_HZ),
        .PAYLOAD_BITS (PB),
        .STOP_BITS    (SB)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .uart_rxd          (rxd),
        .uart_rx_en        (en),
        .uart_rx_break     (brk_o),
        .uart_rx_valid     (valid_o),
        .uart_rx_data      (data_o),
        .uart_rx_frame_err (ferr_o)
`ifdef UART_RX_PARITY_EN
        ,
        .uart_rx_parity_err (perr_o)
`endif
    );

`ifndef UART_RX_PARITY_EN
    assign perr_o = 1'b0;
`endif

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Frame-level rule: what a frame must produce, from its data, stop and parity.
    task automatic expect_frame(input logic [PB-1:0] d, input logic stop_ok, input logic par_ok);
        ev_t ev;
        ev.data = d;
        if (!stop_ok && d == '0)       ev.pulses = P_BRK;
        else if (!stop_ok)             ev.pulses = P_FERR;
        else if (HAS_PAR && !par_ok)   ev.pulses = P_PERR;
        else                           ev.pulses = P_VALID;
        exp_q.push_back(ev);
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int unsigned n);
        rxd = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [PB-1:0] d, input logic stop_ok,
                              input logic par_ok, input logic drop_en);
        drive_bit(1'b0);
        if (drop_en) en = 1'b0;
        for (int i = 0; i < int'(PB); i++) drive_bit(d[i]);
        if (HAS_PAR) drive_bit((^d) ^ ~par_ok);
        for (int s = 0; s < int'(SB); s++) drive_bit(stop_ok);
        if (drop_en) en = 1'b1;
        rxd = 1'b1;
    endtask

    // Per-cycle comparison of every output against the frame model.
    task automatic compare_cycle();
        logic [3:0] got;
        ev_t        ev;
        got = {brk_o, ferr_o, perr_o, valid_o};
        if (!resetn) begin
            mdl_data = '0;
            check("reset_pulses", 32'(got), 32'(P_NONE));
            check("reset_data", 32'(data_o), 32'(mdl_data));
        end else begin
            if (got != P_NONE) begin
                cnt_valid += int'(got[0]);
                cnt_perr  += int'(got[1]);
                cnt_ferr  += int'(got[2]);
                cnt_brk   += int'(got[3]);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 32'(got), 32'(P_NONE));
                end else begin
                    ev = exp_q.pop_front();
                    check("pulse_kind", 32'(got), 32'(ev.pulses));
                    if (ev.pulses == P_VALID) mdl_data = ev.data;
                end
            end
            check("data_hold", 32'(data_o), 32'(mdl_data));
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #5;
            compare_cycle();
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PB-1:0] b;
        resetn = 1'b0;
        rxd    = 1'b1;
        en     = 1'b1;
        repeat (5) @(negedge clk);
        resetn = 1'b1;
        idle_bits(2);

        // Good frame 0xA5.
        expect_frame(8'hA5, 1'b1, 1'b1);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        idle_bits(2);
        check("a5_data", 32'(data_o), 32'h0000_00A5);
        check("a5_valid_count", 32'(cnt_valid), 32'd1);

        // Stop bit low on 0x3C: frame error, data kept.
        expect_frame(8'h3C, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        idle_bits(2);
        check("ferr_data_kept", 32'(data_o), 32'h0000_00A5);
        check("ferr_count", 32'(cnt_ferr), 32'd1);
        check("ferr_no_valid", 32'(cnt_valid), 32'd1);

        // 20 back-to-back random bytes, no idle between frames.
        for (int i = 0; i < 20; i++) begin
            b = PB'($urandom_range(255));
            expect_frame(b, 1'b1, 1'b1);
            send_frame(b, 1'b1, 1'b1, 1'b0);
        end
        idle_bits(2);
        check("b2b_valid_count", 32'(cnt_valid), 32'd21);
        check("b2b_drained", 32'(exp_q.size()), 32'd0);

        // 100 ns glitch: rejected silently, receiver still usable.
        rxd = 1'b0;
        #100;
        rxd = 1'b1;
        idle_bits(2);
        check("glitch_no_pulse", 32'(cnt_valid + cnt_ferr + cnt_brk + cnt_perr), 32'd22);
        expect_frame(8'h96, 1'b1, 1'b1);
        send_frame(8'h96, 1'b1, 1'b1, 1'b0);
        idle_bits(2);
        check("post_glitch_data", 32'(data_o), 32'h0000_0096);

        // Line held low for 12 bit times: exactly one break.
        expect_frame('0, 1'b0, 1'b1);
        rxd = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        idle_bits(3);
        check("break_count", 32'(cnt_brk), 32'd1);
        check("break_data_kept", 32'(data_o), 32'h0000_0096);

        // Enable low: frame ignored.
        en = 1'b0;
        send_frame(8'h11, 1'b1, 1'b1, 1'b0);
        idle_bits(2);
        en = 1'b1;
        idle_bits(1);
        check("en_low_ignored", 32'(cnt_valid), 32'd22);

        // Enable dropped after the start bit: frame still completes.
        expect_frame(8'h22, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1, 1'b1);
        idle_bits(2);
        check("en_drop_data", 32'(data_o), 32'h0000_0022);

        // Reset during bit 4 of 0xFF: partial frame discarded.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rxd = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        idle_bits(6);
        check("reset_data_cleared", 32'(data_o), 32'd0);
        check("reset_no_pulse", 32'(cnt_valid + cnt_ferr + cnt_brk + cnt_perr), 32'd25);
        expect_frame(8'h5A, 1'b1, 1'b1);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        idle_bits(2);
        check("post_reset_data", 32'(data_o), 32'h0000_005A);

        // Parity: wrong then correct parity on 0x07.
        if (HAS_PAR) begin
            expect_frame(8'h07, 1'b1, 1'b0);
            send_frame(8'h07, 1'b1, 1'b0, 1'b0);
            idle_bits(2);
            check("perr_count", 32'(cnt_perr), 32'd1);
            check("perr_data_kept", 32'(data_o), 32'h0000_005A);
            expect_frame(8'h07, 1'b1, 1'b1);
            send_frame(8'h07, 1'b1, 1'b1, 1'b0);
            idle_bits(2);
            check("par_ok_data", 32'(data_o), 32'h0000_0007);
        end

        check("final_drained", 32'(exp_q.size()), 32'd0);
        check("final_valid_count", 32'(cnt_valid), HAS_PAR ? 32'd25 : 32'd24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
